// File: rtl/pipelined_cla_adder_if.sv
// Stream interface of the pipelined CLA adder: operand channel in, {carry-out, sum} channel out.
// Signal names keep the block's port names so the two sides read alike.
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] add1_i;
    logic [WIDTH-1:0] add2_i;
    logic             carry_i;
    logic             approx_en_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH:0]   result_o;

    modport master (
        output in_valid_i, add1_i, add2_i, carry_i, approx_en_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o
    );

    modport slave (
        input  in_valid_i, add1_i, add2_i, carry_i, approx_en_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o
    );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined block carry-lookahead adder: one BLOCK-bit lookahead group per registered stage,
// valid/ready flow control, optional lower-part-OR approximation per transaction.
module pipelined_cla_adder #(
    parameter int WIDTH       = 16,
    parameter int BLOCK       = 4,
    parameter int APPROX_BITS = 4
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    pipelined_cla_adder_if.slave bus
);
    localparam int STAGES = WIDTH / BLOCK;

    logic             valid_r  [STAGES];
    logic             approx_r [STAGES];
    logic             carry_r  [STAGES];
    logic [WIDTH-1:0] sum_r    [STAGES];
    logic [WIDTH-1:0] a_r      [STAGES];
    logic [WIDTH-1:0] b_r      [STAGES];
    logic             load_s   [STAGES];

    // One lookahead group. Approximated bits get p=0 and g=0 except the top approximated
    // bit, whose g=a&b becomes the carry into the exact upper part; their sum is a|b.
    function automatic logic [BLOCK:0] cla_block(
        input logic [BLOCK-1:0] a,
        input logic [BLOCK-1:0] b,
        input logic             approx,
        input int               base,
        input logic             cin
    );
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] p;
        logic [BLOCK-1:0] s;
        logic             pg;
        logic             pp;
        logic             c;
        for (int i = 0; i < BLOCK; i++) begin
            if (approx && (base + i < APPROX_BITS)) begin
                p[i] = 1'b0;
                g[i] = (base + i == APPROX_BITS - 1) ? (a[i] & b[i]) : 1'b0;
            end else begin
                p[i] = a[i] ^ b[i];
                g[i] = a[i] & b[i];
            end
        end
        for (int i = 0; i < BLOCK; i++) begin
            pg = 1'b0;
            pp = 1'b1;
            for (int j = 0; j < i; j++) begin
                pg = g[j] | (p[j] & pg);
                pp = pp & p[j];
            end
            c = pg | (pp & cin);
            if (approx && (base + i < APPROX_BITS)) begin
                s[i] = a[i] | b[i];
            end else begin
                s[i] = p[i] ^ c;
            end
        end
        pg = 1'b0;
        pp = 1'b1;
        for (int i = 0; i < BLOCK; i++) begin
            pg = g[i] | (p[i] & pg);
            pp = pp & p[i];
        end
        return {pg | (pp & cin), s};
    endfunction

    // Ready chain: a stage loads when it or any stage downstream of it can move.
    always_comb begin
        logic chain_s;
        chain_s = bus.out_ready_i;
        for (int k = STAGES - 1; k >= 0; k--) begin
            chain_s   = chain_s | ~valid_r[k];
            load_s[k] = chain_s;
        end
    end

    assign bus.in_ready_o  = load_s[0];
    assign bus.out_valid_o = valid_r[STAGES-1];
    assign bus.result_o    = {carry_r[STAGES-1], sum_r[STAGES-1]};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             src_valid_s;
        logic             src_approx_s;
        logic             src_carry_s;
        logic [WIDTH-1:0] src_sum_s;
        logic [WIDTH-1:0] src_a_s;
        logic [WIDTH-1:0] src_b_s;
        logic [WIDTH-1:0] nxt_sum_s;
        logic [BLOCK:0]   grp_s;

        if (k == 0) begin : g_first
            assign src_valid_s  = bus.in_valid_i;
            assign src_approx_s = bus.approx_en_i;
            assign src_carry_s  = bus.approx_en_i ? 1'b0 : bus.carry_i;
            assign src_sum_s    = {WIDTH{1'b0}};
            assign src_a_s      = bus.add1_i;
            assign src_b_s      = bus.add2_i;
        end else begin : g_next
            assign src_valid_s  = valid_r[k-1];
            assign src_approx_s = approx_r[k-1];
            assign src_carry_s  = carry_r[k-1];
            assign src_sum_s    = sum_r[k-1];
            assign src_a_s      = a_r[k-1];
            assign src_b_s      = b_r[k-1];
        end

        // Resolve this stage's group from the low bits of the remaining operands.
        always_comb begin
            grp_s = cla_block(src_a_s[BLOCK-1:0], src_b_s[BLOCK-1:0], src_approx_s,
                              k * BLOCK, src_carry_s);
            nxt_sum_s = src_sum_s;
            nxt_sum_s[k*BLOCK +: BLOCK] = grp_s[BLOCK-1:0];
        end

        // Stage register; operands shift down so the next group always sits at bit 0.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_r[k]  <= 1'b0;
                approx_r[k] <= 1'b0;
                carry_r[k]  <= 1'b0;
                sum_r[k]    <= {WIDTH{1'b0}};
                a_r[k]      <= {WIDTH{1'b0}};
                b_r[k]      <= {WIDTH{1'b0}};
            end else if (load_s[k]) begin
                valid_r[k] <= src_valid_s;
                if (src_valid_s) begin
                    approx_r[k] <= src_approx_s;
                    carry_r[k]  <= grp_s[BLOCK];
                    sum_r[k]    <= nxt_sum_s;
                    a_r[k]      <= src_a_s >> BLOCK;
                    b_r[k]      <= src_b_s >> BLOCK;
                end
            end
        end
    end
endmodule
